io_write_arbiter: RTL and testbench
===================================

// Module: io_write_arbiter
// PURPOSE
//  Shares the single memory-mapped output-port write interface (io_addr/io_datain/io_write_enable)
//  between NREQ bus masters (req 0 = CPU store path, others = debug/loader masters).
//  Round-robin, one write per two cycles. Validates the port address before issuing; illegal
//  addresses are refused with an error pulse. Sits between the masters and the output-port register bank.
// PARAMETERS
//  NREQ       2          number of requesters (2..4)
//  PORT_BASE  6'b100000  addr[7:2] of output port 0
//  NPORTS     3          number of output ports; legal addr[7:2] = PORT_BASE .. PORT_BASE+NPORTS-1
// PORTS
//  io_clk          in   1         clock, all state updates on posedge
//  resetn          in   1         synchronous, active-low reset
//  req_valid       in   NREQ      request i pending; held with addr/data stable until req_ack[i]
//  req_addr        in   NREQ*32   byte address of request i, slice [32*i +: 32]
//  req_data        in   NREQ*32   write data of request i, slice [32*i +: 32]
//  req_ack         out  NREQ      one-cycle pulse: request i consumed (written or refused)
//  req_err         out  NREQ      one-cycle pulse with req_ack[i]: address illegal, no write issued
//  io_addr         out  32        address to output-port bank
//  io_datain       out  32        data to output-port bank
//  io_write_enable out  1         one-cycle write strobe to output-port bank
//  busy            out  1         1 while in ISSUE state
// BEHAVIOUR
//  Reset (resetn==0 at posedge): state=IDLE; req_ack, req_err, io_write_enable, busy = 0;
//   io_addr, io_datain = 0; last_grant = NREQ-1 (req 0 has top priority first). Applies mid-ISSUE:
//   a strobe pending for the next cycle is cancelled, no ack is given; requester keeps valid and retries.
//  FSM, all outputs registered:
//   IDLE : if any req_valid -> winner w = first set bit scanning last_grant+1, +2, ... (mod NREQ);
//          latch io_addr=req_addr[w], io_datain=req_data[w]; legal = (addr[7:2] in port range);
//          next cycle: req_ack[w]=1, req_err[w]=!legal, io_write_enable=legal, busy=1; last_grant=w;
//          state -> ISSUE. No valid -> stay IDLE, all pulses 0, io_addr/io_datain hold.
//   ISSUE: pulses drop to 0 at next edge; busy=0; state -> IDLE unconditionally (dead cycle lets
//          the acked master drop or replace valid; prevents double issue).
//  Latency: valid sampled at edge k -> strobe + ack high during cycle k+1 -> bank writes at edge k+2.
//  Throughput: max 1 write per 2 cycles; with all NREQ valid, each master served once per 2*NREQ cycles.
//  Address legality uses addr[7:2] only (bank decodes [7:2] only); addr[31:8], addr[1:0] ignored.
//  Valid still high in the cycle after ack = a new request; it competes normally (RR excludes starvation).
//  req_valid dropped before ack: request vanishes, no side effect (permitted but non-compliant master).
//  Exactly one req_ack bit at most per cycle; req_err never set without req_ack.
//  Illegal request still advances last_grant (fairness preserved).
// STRUCTURE
//  Shared package io_pkg: IO_PORT_BASE, IO_NPORTS, state encoding (ST_IDLE, ST_ISSUE),
//   function is_io_port(addr) -> legal bit. Output-port bank uses the same constants.
//  Sub-module rr_pick (combinational): inputs req[NREQ], last[log2 NREQ]; outputs any, grant index.
//  Top: FSM + latches + pulse registers; ~150-250 lines.
// TESTING
//  1 Reset then req_valid=01, addr0=0x80, data0=0xDEADBEEF -> cycle+1: io_write_enable=1,
//    io_addr=0x80, io_datain=0xDEADBEEF, req_ack=01, req_err=00; next cycle all 0, busy=0.
//  2 Both valid, addr0=0x84/data 0x1, addr1=0x88/data 0x2, held -> grants alternate 0,1,0,1 with
//    strobe every 2nd cycle; first grant is req 0.
//  3 req1 addr=0x8C (addr[7:2]=35) -> req_ack=10, req_err=10, io_write_enable=0; next grant goes to req 0.
//  4 addr=0xFFFF_FF80 -> treated as port 0 (upper bits ignored), write issued, no error.
//  5 resetn=0 on the edge entering ISSUE -> io_write_enable, req_ack stay 0; after release same
//    request re-arbitrated and written exactly once.
//  6 Single master valid continuously for 10 cycles -> exactly 5 strobes/acks, none back-to-back.

Source files
------------

// File: rtl/io_pkg.sv
// Constants and helpers shared by the output-port write arbiter and the output-port register bank.
package io_pkg;

  localparam logic [5:0] IO_PORT_BASE = 6'b100000;
  localparam int         IO_NPORTS    = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } io_state_t;

  // The bank decodes addr[7:2] only, so the upper bits and the byte offset play no part here.
  function automatic logic is_io_port(input logic [31:0] addr,
                                      input logic [5:0]  base   = IO_PORT_BASE,
                                      input int          nports = IO_NPORTS);
    int word;
    word = int'(addr[7:2]);
    return (word >= int'(base)) && (word < int'(base) + nports);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit scanning from last+1 upward, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic            any,
  output logic [LW-1:0]   grant
);

  logic found;
  int   idx;

  always_comb begin
    any   = |req;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter sharing the output-port write interface between NREQ masters, with
// address validation; one write (or refusal) per two cycles, all outputs registered.
//   state    | meaning
//   ST_IDLE  | no pulse outstanding; arbitrate on any req_valid
//   ST_ISSUE | ack/strobe high this cycle; dead cycle before next arbitration
module io_write_arbiter
  import io_pkg::*;
#(
  parameter int         NREQ      = 2,
  parameter logic [5:0] PORT_BASE = IO_PORT_BASE,
  parameter int         NPORTS    = IO_NPORTS
) (
  input  logic                 io_clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          io_addr,
  output logic [31:0]          io_datain,
  output logic                 io_write_enable,
  output logic                 busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  io_state_t       state, state_n;
  logic [LW-1:0]   last_grant, last_n;
  logic [NREQ-1:0] ack_n, err_n;
  logic [31:0]     addr_n, data_n;
  logic [31:0]     sel_addr, sel_data;
  logic            we_n, busy_n, legal;
  logic            any;
  logic [LW-1:0]   grant;

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant),
    .any   (any),
    .grant (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (LW'(i) == grant) begin
        sel_addr = req_addr[32*i +: 32];
        sel_data = req_data[32*i +: 32];
      end
    end
    legal = is_io_port(sel_addr, PORT_BASE, NPORTS);
  end

  always_comb begin
    state_n = state;
    last_n  = last_grant;
    addr_n  = io_addr;
    data_n  = io_datain;
    ack_n   = '0;
    err_n   = '0;
    we_n    = 1'b0;
    busy_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          addr_n  = sel_addr;
          data_n  = sel_data;
          we_n    = legal;
          busy_n  = 1'b1;
          last_n  = grant;
          state_n = ST_ISSUE;
          for (int i = 0; i < NREQ; i++) begin
            ack_n[i] = (LW'(i) == grant);
            err_n[i] = (LW'(i) == grant) && !legal;
          end
        end
      end
      // Dead cycle: the acked master drops or replaces valid before anyone is arbitrated again.
      ST_ISSUE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      last_grant      <= LW'(NREQ - 1);
      io_addr         <= '0;
      io_datain       <= '0;
      req_ack         <= '0;
      req_err         <= '0;
      io_write_enable <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      last_grant      <= last_n;
      io_addr         <= addr_n;
      io_datain       <= data_n;
      req_ack         <= ack_n;
      req_err         <= err_n;
      io_write_enable <= we_n;
      busy            <= busy_n;
    end
  end

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench for io_write_arbiter (NREQ=2): hand-computed expectations checked #1 after each edge.
module tb_io_write_arbiter;

  localparam int NREQ = 2;

  logic                io_clk = 1'b0;
  logic                resetn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_addr;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     req_err;
  logic [31:0]         io_addr;
  logic [31:0]         io_datain;
  logic                io_write_enable;
  logic                busy;

  int checks = 0;
  int errors = 0;

  io_write_arbiter #(.NREQ(NREQ)) dut (
    .io_clk          (io_clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .req_err         (req_err),
    .io_addr         (io_addr),
    .io_datain       (io_datain),
    .io_write_enable (io_write_enable),
    .busy            (busy)
  );

  always #5 io_clk = ~io_clk;

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   {31'd0, io_write_enable}, 32'd0);
    chk({tag, ".ack"},  {30'd0, req_ack}, 32'd0);
    chk({tag, ".err"},  {30'd0, req_err}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  int          n_we, n_ack;
  logic        prev_we, b2b;
  logic [1:0]  exp_ack;

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset.io_addr",   io_addr,   32'd0);
    chk("reset.io_datain", io_datain, 32'd0);

    // 1: single legal write from req 0
    resetn    = 1'b1;
    req_valid = 2'b01;
    req_addr[31:0] = 32'h0000_0080;
    req_data[31:0] = 32'hDEAD_BEEF;
    tick();
    chk("t1.we",      {31'd0, io_write_enable}, 32'd1);
    chk("t1.io_addr", io_addr,   32'h0000_0080);
    chk("t1.io_data", io_datain, 32'hDEAD_BEEF);
    chk("t1.ack",     {30'd0, req_ack}, 32'h1);
    chk("t1.err",     {30'd0, req_err}, 32'h0);
    chk("t1.busy",    {31'd0, busy}, 32'd1);
    req_valid = 2'b00;
    tick();
    chk_idle("t1.after");

    // 2: both held, alternating grants starting at req 0
    do_reset();
    req_valid = 2'b11;
    req_addr  = {32'h0000_0088, 32'h0000_0084};
    req_data  = {32'h0000_0002, 32'h0000_0001};
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c % 2 == 0) begin
        exp_ack = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("t2.ack%0d", c), {30'd0, req_ack}, {30'd0, exp_ack});
        chk($sformatf("t2.we%0d", c),  {31'd0, io_write_enable}, 32'd1);
        chk($sformatf("t2.addr%0d", c), io_addr, exp_ack[0] ? 32'h84 : 32'h88);
        chk($sformatf("t2.data%0d", c), io_datain, exp_ack[0] ? 32'h1 : 32'h2);
      end else begin
        chk_idle($sformatf("t2.gap%0d", c));
      end
    end
    req_valid = 2'b00;
    tick();

    // 3: illegal port 35 refused, fairness still moves to req 0
    req_valid = 2'b10;
    req_addr  = {32'h0000_008C, 32'h0000_0080};
    req_data  = {32'h0000_0033, 32'h0000_0044};
    tick();
    chk("t3.ack",  {30'd0, req_ack}, 32'h2);
    chk("t3.err",  {30'd0, req_err}, 32'h2);
    chk("t3.we",   {31'd0, io_write_enable}, 32'd0);
    chk("t3.busy", {31'd0, busy}, 32'd1);
    req_valid = 2'b11;
    tick();
    chk_idle("t3.gap");
    tick();
    chk("t3.next_ack",  {30'd0, req_ack}, 32'h1);
    chk("t3.next_err",  {30'd0, req_err}, 32'h0);
    chk("t3.next_we",   {31'd0, io_write_enable}, 32'd1);
    chk("t3.next_addr", io_addr, 32'h0000_0080);
    req_valid = 2'b00;
    tick();

    // 3b: port just below the base (addr[7:2]=31) is refused
    req_valid = 2'b01;
    req_addr[31:0] = 32'h0000_007C;
    tick();
    chk("t3b.err", {30'd0, req_err}, 32'h1);
    chk("t3b.we",  {31'd0, io_write_enable}, 32'd0);
    req_valid = 2'b00;
    tick();

    // 4: upper address bits ignored
    req_valid = 2'b01;
    req_addr[31:0] = 32'hFFFF_FF80;
    req_data[31:0] = 32'h0000_0055;
    tick();
    chk("t4.we",      {31'd0, io_write_enable}, 32'd1);
    chk("t4.ack",     {30'd0, req_ack}, 32'h1);
    chk("t4.err",     {30'd0, req_err}, 32'h0);
    chk("t4.io_addr", io_addr, 32'hFFFF_FF80);
    req_valid = 2'b00;
    tick();

    // 5: reset on the edge that would enter ISSUE, then retried once
    req_valid = 2'b01;
    req_addr[31:0] = 32'h0000_0088;
    req_data[31:0] = 32'h0000_0077;
    resetn = 1'b0;
    tick();
    chk_idle("t5.rst");
    resetn = 1'b1;
    n_we = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (io_write_enable) begin
        n_we++;
        chk("t5.addr", io_addr,   32'h0000_0088);
        chk("t5.data", io_datain, 32'h0000_0077);
        chk("t5.ack",  {30'd0, req_ack}, 32'h1);
      end
      if (req_ack[0]) req_valid = 2'b00;
    end
    chk("t5.writes", n_we, 32'd1);

    // 6: continuous single master for 10 cycles
    req_valid = 2'b01;
    req_addr[31:0] = 32'h0000_0084;
    n_we = 0;
    n_ack = 0;
    prev_we = 1'b0;
    b2b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (io_write_enable) n_we++;
      if (req_ack != 2'b00) n_ack++;
      if (io_write_enable && prev_we) b2b = 1'b1;
      prev_we = io_write_enable;
    end
    chk("t6.strobes", n_we, 32'd5);
    chk("t6.acks",    n_ack, 32'd5);
    chk("t6.b2b",     {31'd0, b2b}, 32'd0);
    req_valid = 2'b00;
    tick();
    tick();
    chk_idle("t6.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
